// File: rtl/sm_pkg.sv
// Shared definitions for the stepper-motor tracking path (TR, TR_pulse, ramp control).
package sm_pkg;

   // Period bus width in clk cycles, shared with TR and TR_pulse.
   localparam int unsigned SM_N_W         = 17;

   // Default period limits at 50 MHz: 1000 -> 50 kHz, 8333 -> 6 kHz.
   localparam int unsigned SM_N_MIN       = 1000;
   localparam int unsigned SM_N_MAX       = 8333;

   // Default maximum period change per emitted step.
   localparam int unsigned SM_RAMP_STEP   = 16;

   // Ramp controller states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RAMP   = 2'd1,
      ST_CRUISE = 2'd2,
      ST_BRAKE  = 2'd3
   } sm_state_t;

endpackage

// File: rtl/sm_ramp_step.sv
// Combinational next-period calculation: move the current period toward a goal
// by at most RAMP_STEP, landing exactly on the goal when it is within reach.
module sm_ramp_step
   import sm_pkg::*;
#(
   parameter int unsigned N_W       = SM_N_W,
   parameter int unsigned N_MIN     = SM_N_MIN,
   parameter int unsigned N_MAX     = SM_N_MAX,
   parameter int unsigned RAMP_STEP = SM_RAMP_STEP
) (
   input  logic [N_W-1:0] i_cur_n,
   input  logic [N_W-1:0] i_goal,
   output logic [N_W-1:0] o_nxt_n
);

   localparam logic [N_W:0] LP_STEP = (N_W+1)'(RAMP_STEP);
   localparam logic [N_W:0] LP_MIN  = (N_W+1)'(N_MIN);
   localparam logic [N_W:0] LP_MAX  = (N_W+1)'(N_MAX);

   logic [N_W:0] w_cur;
   logic [N_W:0] w_goal;
   logic [N_W:0] w_diff;
   logic [N_W:0] w_up;
   logic [N_W:0] w_dn;
   logic [N_W:0] w_res;

   // One extra bit of headroom so the +STEP sum cannot wrap; the -STEP path floors at zero
   // before the final saturation to [N_MIN, N_MAX].
   always_comb begin
      w_cur  = {1'b0, i_cur_n};
      w_goal = {1'b0, i_goal};
      w_up   = w_cur + LP_STEP;
      w_dn   = (w_cur >= LP_STEP) ? (w_cur - LP_STEP) : '0;
      if (w_goal >= w_cur) begin
         w_diff = w_goal - w_cur;
         w_res  = (w_diff <= LP_STEP) ? w_goal : w_up;
      end else begin
         w_diff = w_cur - w_goal;
         w_res  = (w_diff <= LP_STEP) ? w_goal : w_dn;
      end
      if (w_res > LP_MAX) w_res = LP_MAX;
      if (w_res < LP_MIN) w_res = LP_MIN;
      o_nxt_n = w_res[N_W-1:0];
   end

endmodule

// File: rtl/sm_ramp_ctrl.sv
// Acceleration/deceleration scheduler between TR and TR_pulse. Stops and reversals
// always brake to the slowest period first; the period changes only on emitted steps.
module sm_ramp_ctrl
   import sm_pkg::*;
#(
   parameter int unsigned N_W       = SM_N_W,
   parameter int unsigned N_MIN     = SM_N_MIN,
   parameter int unsigned N_MAX     = SM_N_MAX,
   parameter int unsigned RAMP_STEP = SM_RAMP_STEP
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           tgt_valid,
   input  logic           tgt_en,
   input  logic           tgt_dir,
   input  logic [N_W-1:0] tgt_n,
   input  logic           step_done,
   output logic           out_en,
   output logic           out_dir,
   output logic [N_W-1:0] out_n,
   output logic           busy,
   output logic           at_speed
);

   localparam logic [N_W-1:0] LP_MIN = N_W'(N_MIN);
   localparam logic [N_W-1:0] LP_MAX = N_W'(N_MAX);

   sm_state_t      r_state;
   logic           r_tgt_en;
   logic           r_tgt_dir;
   logic [N_W-1:0] r_tgt_n;
   logic           r_out_en;
   logic           r_out_dir;
   logic [N_W-1:0] r_out_n;

   logic [N_W-1:0] w_tgt_clamped;
   logic [N_W-1:0] w_goal;
   logic [N_W-1:0] w_nxt_n;
   logic           w_abort;

   // Clamp the incoming request into the legal period window.
   always_comb begin
      w_tgt_clamped = tgt_n;
      if (tgt_n < LP_MIN) w_tgt_clamped = LP_MIN;
      if (tgt_n > LP_MAX) w_tgt_clamped = LP_MAX;
   end

   // Braking always heads for the slowest period; otherwise follow the latched target.
   always_comb begin
      w_goal  = (r_state == ST_BRAKE) ? LP_MAX : r_tgt_n;
      w_abort = !r_tgt_en || (r_tgt_dir != r_out_dir);
   end

   sm_ramp_step #(
      .N_W       (N_W),
      .N_MIN     (N_MIN),
      .N_MAX     (N_MAX),
      .RAMP_STEP (RAMP_STEP)
   ) u_step (
      .i_cur_n (r_out_n),
      .i_goal  (w_goal),
      .o_nxt_n (w_nxt_n)
   );

   // Target latch: hold the last request from TR until the next strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tgt_en  <= 1'b0;
         r_tgt_dir <= 1'b0;
         r_tgt_n   <= LP_MAX;
      end else if (tgt_valid) begin
         r_tgt_en  <= tgt_en;
         r_tgt_dir <= tgt_dir;
         r_tgt_n   <= w_tgt_clamped;
      end
   end

   // Ramp state machine and output period register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_out_en  <= 1'b0;
         r_out_dir <= 1'b0;
         r_out_n   <= LP_MAX;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (r_tgt_en) begin
                  r_out_en  <= 1'b1;
                  r_out_dir <= r_tgt_dir;
                  r_out_n   <= LP_MAX;
                  r_state   <= (r_tgt_n == LP_MAX) ? ST_CRUISE : ST_RAMP;
               end
            end
            ST_RAMP: begin
               // An abort takes priority and discards any coincident step.
               if (w_abort) begin
                  r_state <= ST_BRAKE;
               end else if (step_done) begin
                  r_out_n <= w_nxt_n;
                  if (w_nxt_n == r_tgt_n) r_state <= ST_CRUISE;
               end
            end
            ST_CRUISE: begin
               if (w_abort)                   r_state <= ST_BRAKE;
               else if (r_tgt_n != r_out_n)   r_state <= ST_RAMP;
            end
            ST_BRAKE: begin
               if (step_done) begin
                  if (r_out_n == LP_MAX) begin
                     if (!r_tgt_en) begin
                        r_out_en <= 1'b0;
                        r_state  <= ST_IDLE;
                     end else if (r_tgt_dir != r_out_dir) begin
                        r_out_dir <= r_tgt_dir;
                        r_state   <= (r_tgt_n == LP_MAX) ? ST_CRUISE : ST_RAMP;
                     end else begin
                        r_state <= ST_RAMP;
                     end
                  end else begin
                     r_out_n <= w_nxt_n;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign out_en   = r_out_en;
   assign out_dir  = r_out_dir;
   assign out_n    = r_out_n;
   assign busy     = (r_state != ST_IDLE);
   assign at_speed = (r_state == ST_CRUISE);

endmodule

// File: tb/tb_sm_ramp_ctrl.sv
// Self-checking bench for sm_ramp_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model.
module tb_sm_ramp_ctrl;

   localparam int NW   = 17;
   localparam int NMIN = 100;
   localparam int NMAX = 200;
   localparam int STEP = 16;

   localparam int M_IDLE   = 0;
   localparam int M_RAMP   = 1;
   localparam int M_CRUISE = 2;
   localparam int M_BRAKE  = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          tgt_valid = 1'b0;
   logic          tgt_en = 1'b0;
   logic          tgt_dir = 1'b0;
   logic [NW-1:0] tgt_n = '0;
   logic          step_done = 1'b0;
   logic          out_en;
   logic          out_dir;
   logic [NW-1:0] out_n;
   logic          busy;
   logic          at_speed;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: motor enable/direction/period plus the latched request.
   int m_mode, m_en, m_dir, m_n;
   int t_en, t_dir, t_n;

   sm_ramp_ctrl #(
      .N_W       (NW),
      .N_MIN     (NMIN),
      .N_MAX     (NMAX),
      .RAMP_STEP (STEP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .tgt_valid (tgt_valid),
      .tgt_en    (tgt_en),
      .tgt_dir   (tgt_dir),
      .tgt_n     (tgt_n),
      .step_done (step_done),
      .out_en    (out_en),
      .out_dir   (out_dir),
      .out_n     (out_n),
      .busy      (busy),
      .at_speed  (at_speed)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1);
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int clampn(input int v);
      if (v < NMIN) return NMIN;
      if (v > NMAX) return NMAX;
      return v;
   endfunction

   // Move n toward g by at most STEP, never overshooting.
   function automatic int toward(input int n, input int g);
      if (g > n) return (n + STEP > g) ? g : n + STEP;
      return (n - STEP < g) ? g : n - STEP;
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE; m_en = 0; m_dir = 0; m_n = NMAX;
      t_en = 0; t_dir = 0; t_n = NMAX;
   endtask

   task automatic model_clock(input int v, input int e, input int d, input int n, input int sd);
      bit wants_stop;
      wants_stop = (t_en == 0) || (t_dir != m_dir);
      case (m_mode)
         M_IDLE: if (t_en != 0) begin
            m_en = 1; m_dir = t_dir; m_n = NMAX;
            m_mode = (t_n == NMAX) ? M_CRUISE : M_RAMP;
         end
         M_RAMP: begin
            if (wants_stop) m_mode = M_BRAKE;
            else if (sd != 0) begin
               m_n = toward(m_n, t_n);
               if (m_n == t_n) m_mode = M_CRUISE;
            end
         end
         M_CRUISE: begin
            if (wants_stop) m_mode = M_BRAKE;
            else if (t_n != m_n) m_mode = M_RAMP;
         end
         default: if (sd != 0) begin
            if (m_n != NMAX) m_n = toward(m_n, NMAX);
            else if (t_en == 0) begin m_en = 0; m_mode = M_IDLE; end
            else if (t_dir != m_dir) begin
               m_dir = t_dir;
               m_mode = (t_n == NMAX) ? M_CRUISE : M_RAMP;
            end else m_mode = M_RAMP;
         end
      endcase
      if (v != 0) begin t_en = e; t_dir = d; t_n = clampn(n); end
   endtask

   task automatic cmp_all();
      chk("out_en",   int'(out_en),   m_en);
      chk("out_dir",  int'(out_dir),  m_dir);
      chk("out_n",    int'(out_n),    m_n);
      chk("busy",     int'(busy),     int'(m_mode != M_IDLE));
      chk("at_speed", int'(at_speed), int'(m_mode == M_CRUISE));
   endtask

   // One clock: drive inputs, advance model on the edge, compare 1 ns later.
   task automatic tick(input int v, input int e, input int d, input int n, input int sd);
      int prev_n, prev_dir, dn;
      tgt_valid = v[0]; tgt_en = e[0]; tgt_dir = d[0]; tgt_n = NW'(n); step_done = sd[0];
      prev_n = int'(out_n); prev_dir = int'(out_dir);
      @(posedge clk);
      if (rst) model_clock(v, e, d, n, sd);
      else     model_reset();
      #1;
      tgt_valid = 1'b0; step_done = 1'b0;
      cmp_all();
      dn = int'(out_n) - prev_n;
      if (rst) chk("slew", int'(dn <= STEP && dn >= -STEP), 1);
      if (int'(out_dir) != prev_dir) chk("dir_change_at_nmax", int'(out_n), NMAX);
   endtask

   task automatic idle();
      tick(0, 0, 0, 0, 0);
   endtask

   task automatic req(input int e, input int d, input int n);
      tick(1, e, d, n, 0);
      idle();
   endtask

   task automatic step_exp(input string tag, input int exp);
      tick(0, 0, 0, 0, 1);
      chk(tag, int'(out_n), exp);
      idle();
   endtask

   task automatic stop_all();
      req(0, 0, NMAX);
      for (int i = 0; i < 20; i++) begin
         if (!busy) break;
         tick(0, 0, 0, 0, 1);
         idle();
      end
      chk("stop_reached_idle", int'(busy), 0);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_en", int'(out_en), 0);
      chk("rst_out_dir", int'(out_dir), 0);
      chk("rst_out_n", int'(out_n), NMAX);
      chk("rst_busy", int'(busy), 0);
      chk("rst_at_speed", int'(at_speed), 0);
      rst = 1'b1;

      // Start: en=1, dir=1, n=150.
      tick(1, 1, 1, 150, 0);
      chk("start_en_t1", int'(out_en), 0);
      idle();
      chk("start_en_t2", int'(out_en), 1);
      chk("start_dir", int'(out_dir), 1);
      chk("start_n", int'(out_n), 200);
      step_exp("start_s1", 184);
      step_exp("start_s2", 168);
      step_exp("start_s3", 152);
      step_exp("start_s4", 150);
      chk("start_at_speed", int'(at_speed), 1);

      // Reverse from cruise at 150.
      req(1, 0, 150);
      step_exp("rev_b1", 166);
      step_exp("rev_b2", 182);
      step_exp("rev_b3", 198);
      step_exp("rev_b4", 200);
      chk("rev_dir_held", int'(out_dir), 1);
      tick(0, 0, 0, 0, 1);
      chk("rev_dir_flip", int'(out_dir), 0);
      chk("rev_flip_n", int'(out_n), 200);
      idle();
      step_exp("rev_a1", 184);
      step_exp("rev_a2", 168);
      step_exp("rev_a3", 152);
      step_exp("rev_a4", 150);
      chk("rev_at_speed", int'(at_speed), 1);

      // Stop from cruise at 150.
      req(0, 0, 150);
      step_exp("stop_b1", 166);
      step_exp("stop_b2", 182);
      step_exp("stop_b3", 198);
      step_exp("stop_b4", 200);
      tick(0, 0, 0, 0, 1);
      chk("stop_out_en", int'(out_en), 0);
      chk("stop_busy", int'(busy), 0);

      // Collision: new target strobed together with a step.
      req(1, 0, 150);
      step_exp("col_s1", 184);
      tick(1, 1, 0, 120, 1);
      chk("col_old_tgt", int'(out_n), 168);
      idle();
      step_exp("col_s3", 152);
      step_exp("col_s4", 136);
      step_exp("col_s5", 120);
      chk("col_at_speed", int'(at_speed), 1);

      // Clamp low: n=20 ramps down to N_MIN and no further.
      stop_all();
      req(1, 1, 20);
      for (int k = 1; k <= 7; k++) begin
         step_exp("clamp_lo", (200 - 16 * k < NMIN) ? NMIN : 200 - 16 * k);
      end
      step_exp("clamp_lo_hold", NMIN);
      chk("clamp_lo_at_speed", int'(at_speed), 1);

      // Clamp high: n=500 cruises at N_MAX immediately.
      stop_all();
      req(1, 1, 500);
      chk("clamp_hi_n", int'(out_n), NMAX);
      chk("clamp_hi_at_speed", int'(at_speed), 1);

      // Asynchronous reset mid-ramp.
      req(1, 1, 150);
      step_exp("rst_ramp_s1", 184);
      #1 rst = 1'b0;
      model_reset();
      #1;
      chk("arst_out_en", int'(out_en), 0);
      chk("arst_out_n", int'(out_n), NMAX);
      chk("arst_busy", int'(busy), 0);
      tick(0, 0, 0, 0, 1);
      rst = 1'b1;
      repeat (3) tick(0, 0, 0, 0, 1);
      chk("post_rst_en", int'(out_en), 0);
      chk("post_rst_n", int'(out_n), NMAX);
      chk("post_rst_busy", int'(busy), 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         int v, e, d, n, sd;
         v  = ($urandom_range(0, 14) == 0) ? 1 : 0;
         e  = ($urandom_range(0, 7) != 0) ? 1 : 0;
         d  = int'($urandom_range(0, 1));
         n  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(80, 220))
                                          : int'($urandom_range(0, 600));
         sd = ($urandom_range(0, 2) == 0) ? 1 : 0;
         if ($urandom_range(0, 799) == 0) begin
            rst = 1'b0;
            model_reset();
            tick(0, 0, 0, 0, 0);
            rst = 1'b1;
         end else begin
            tick(v, e, d, n, sd);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
